// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter and single-outstanding access sequencer in front of the RCD register map.
// Optional compile-time feature: define REG_ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES.
module reg_access_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic [ADDR_WIDTH-1:0]         reg_addr_o,
  output logic                          reg_rd_req_o,
  output logic                          reg_wr_req_o,
  output logic [DATA_WIDTH-1:0]         reg_wr_data_o,
  input  logic [DATA_WIDTH-1:0]         reg_rd_data_i,
  input  logic                          reg_ack_i,
  input  logic                          reg_err_i,
  output logic                          busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic                   cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic                   rd_req_q, rd_req_d;
  logic                   wr_req_q, wr_req_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   abort;
`ifdef REG_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  logic                   grant_found;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand_idx;

  // Search starts one past the last winner so every requester is served within NUM_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand_idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    abort        = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d      = ST_ISSUE;
          last_grant_d = grant_idx;
          cmd_we_d     = req_we_i[grant_idx];
          cmd_addr_d   = req_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          cmd_wdata_d  = req_wdata_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
          rd_req_d     = !req_we_i[grant_idx];
          wr_req_d     = req_we_i[grant_idx];
`ifdef REG_ARB_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      ST_ISSUE: begin
`ifdef REG_ARB_TIMEOUT_EN
        if (!reg_ack_i && !reg_err_i) begin
          if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) abort = 1'b1;
          else tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
        // An err without ack is a NACK; either way err passes straight through to the requester.
        if (reg_ack_i || reg_err_i || abort) begin
          state_d     = ST_RESP;
          rd_req_d    = 1'b0;
          wr_req_d    = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << last_grant_q;
          rsp_err_d   = reg_err_i || abort;
          rsp_rdata_d = (reg_ack_i && !cmd_we_q) ? reg_rd_data_i : '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
`ifdef REG_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  // Ready is gated by reset so a requester is never told it was accepted while the flops are held.
  assign req_ready_o   = (rst_ni && state_q == ST_IDLE && grant_found) ?
                         (NUM_REQ'(1) << grant_idx) : '0;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign reg_addr_o    = cmd_addr_q;
  assign reg_wr_data_o = cmd_wdata_q;
  assign reg_rd_req_o  = rd_req_q;
  assign reg_wr_req_o  = wr_req_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
